// File: rtl/ifetch_requester_if.sv
// Instruction-bus split-transaction channel between the fetch front end
// (master) and the instruction cache (slave).
interface ifetch_requester_if;
    logic        ibus_valid;
    logic [31:0] ibus_address;
    logic        ibus_uncache;
    logic [1:0]  ibus_size;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_rdata;

    modport master (
        output ibus_valid, ibus_address, ibus_uncache, ibus_size,
        input  ibus_addr_ok, ibus_data_ok, ibus_rdata
    );

    modport slave (
        input  ibus_valid, ibus_address, ibus_uncache, ibus_size,
        output ibus_addr_ok, ibus_data_ok, ibus_rdata
    );
endinterface

// File: rtl/ifetch_requester.sv
// Fetch front end: issues sequential PCs on the instruction bus, tracks in-order
// responses, buffers returned words for decode and squashes stale responses on redirect.
module ifetch_requester #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    ifetch_requester_if.master        ibus,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      inst_valid,
    output logic [31:0]               inst_pc,
    output logic [31:0]               inst_data,
    input  logic                      inst_ready
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 2);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   pc_reg, pc_next, hold_addr_reg, req_addr;
    logic          req_hold_reg, req_hold_next, hold_stale_reg, hold_stale_next;
    logic [CW-1:0] out_reg, out_next, discard_reg, discard_next;
    logic [QW-1:0] q_wr_reg, q_rd_reg;
    logic [FW-1:0] f_wr_reg, f_rd_reg;
    logic [FW:0]   f_cnt_reg;
    logic [31:0]   q_mem  [MAX_OUTSTANDING];
    logic [31:0]   f_pc   [FIFO_DEPTH];
    logic [31:0]   f_data [FIFO_DEPTH];

    logic can_issue, req_valid, accept, resp, drop, push, pop;
    int   credit_sum;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (32'(p) == 32'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count outstanding requests against free FIFO slots so every kept
    // response is guaranteed a place to land.
    always_comb begin
        credit_sum = int'(out_reg) + int'(f_cnt_reg);
        can_issue  = (credit_sum < FIFO_DEPTH) && (int'(out_reg) < MAX_OUTSTANDING);
        req_valid  = !reset && (req_hold_reg || can_issue);
        req_addr   = req_hold_reg ? hold_addr_reg : pc_reg;
        accept     = req_valid && ibus.ibus_addr_ok;
        resp       = ibus.ibus_data_ok && (out_reg != '0);
        drop       = resp && (discard_reg != '0);
        push       = resp && (discard_reg == '0) && !redirect_valid;
        pop        = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        out_next      = out_reg + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, resp};
        req_hold_next = req_valid && !ibus.ibus_addr_ok;
        // A held request that survived a redirect still carries its old address.
        hold_stale_next = req_hold_next && ((req_hold_reg && hold_stale_reg) || redirect_valid);

        pc_next = pc_reg;
        if (accept && !(req_hold_reg && hold_stale_reg))
            pc_next = pc_reg + 32'd4;
        if (redirect_valid)
            pc_next = redirect_pc & 32'hffff_fffc;

        discard_next = discard_reg - {{(CW-1){1'b0}}, drop};
        if (redirect_valid)
            discard_next = out_next + {{(CW-1){1'b0}}, req_hold_next};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            hold_addr_reg  <= '0;
            req_hold_reg   <= 1'b0;
            hold_stale_reg <= 1'b0;
            out_reg        <= '0;
            discard_reg    <= '0;
            q_wr_reg       <= '0;
            q_rd_reg       <= '0;
            f_wr_reg       <= '0;
            f_rd_reg       <= '0;
            f_cnt_reg      <= '0;
        end else begin
            pc_reg         <= pc_next;
            hold_addr_reg  <= req_addr;
            req_hold_reg   <= req_hold_next;
            hold_stale_reg <= hold_stale_next;
            out_reg        <= out_next;
            discard_reg    <= discard_next;
            if (accept)
                q_wr_reg <= q_inc(q_wr_reg);
            if (resp)
                q_rd_reg <= q_inc(q_rd_reg);
            if (redirect_valid) begin
                f_wr_reg  <= '0;
                f_rd_reg  <= '0;
                f_cnt_reg <= '0;
            end else begin
                if (push)
                    f_wr_reg <= f_wr_reg + 1'b1;
                if (pop)
                    f_rd_reg <= f_rd_reg + 1'b1;
                f_cnt_reg <= f_cnt_reg + {{FW{1'b0}}, push} - {{FW{1'b0}}, pop};
            end
        end
    end

    // Storage arrays carry no reset; pointers and counters define their contents.
    always_ff @(posedge clk) begin
        if (accept)
            q_mem[q_wr_reg] <= req_addr;
        if (push) begin
            f_pc[f_wr_reg]   <= q_mem[q_rd_reg];
            f_data[f_wr_reg] <= ibus.ibus_rdata;
        end
    end

    assign ibus.ibus_valid   = req_valid;
    assign ibus.ibus_address = req_addr;
    assign ibus.ibus_uncache = (req_addr[31:29] == 3'b101);
    assign ibus.ibus_size    = 2'b10;

    assign inst_valid = (f_cnt_reg != '0);
    assign inst_pc    = inst_valid ? f_pc[f_rd_reg]   : 32'd0;
    assign inst_data  = inst_valid ? f_data[f_rd_reg] : 32'd0;

    data_ok_without_request: assert property (
        @(posedge clk) disable iff (reset) !(ibus.ibus_data_ok && (out_reg == '0)));
endmodule

// File: tb/tb_ifetch_requester.sv
// Directed bench for ifetch_requester: sequential fetch, request hold, FIFO
// back-pressure, redirect with outstanding and with held requests.
module tb_ifetch_requester;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    int          total = 0;
    int          bad   = 0;

    ifetch_requester_if bus ();

    ifetch_requester dut (
        .clk            (clk),
        .reset          (reset),
        .ibus           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) $display("ok   %-16s %h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic aok, input logic dok, input logic [31:0] rd, input logic rdy);
        bus.ibus_addr_ok = aok;
        bus.ibus_data_ok = dok;
        bus.ibus_rdata   = rd;
        inst_ready       = rdy;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'd0;
        bus.ibus_addr_ok = 1'b0;
        bus.ibus_data_ok = 1'b0;
        bus.ibus_rdata   = 32'd0;
        inst_ready       = 1'b0;
        advance();
        advance();
        chk("rst_ibus_valid", bus.ibus_valid, 32'd0);
        chk("rst_inst_valid", inst_valid, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_first_addr", bus.ibus_address, 32'hbfc00000);
    endtask

    initial begin
        // Sequential fetch, one-cycle response latency, decode always ready.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            drive(k < 12, (k >= 1) && (k <= 12), 32'ha5000000 | 32'(k - 1), 1'b1);
            if (k == 0) begin
                chk("t1_uncache", bus.ibus_uncache, 32'd1);
                chk("t1_size", bus.ibus_size, 32'd2);
            end
            if (k < 12) begin
                chk("t1_valid", bus.ibus_valid, 32'd1);
                chk("t1_addr", bus.ibus_address, 32'hbfc00000 + 32'(4 * k));
            end
            if (k >= 2) begin
                chk("t1_inst_valid", inst_valid, 32'd1);
                chk("t1_inst_pc", inst_pc, 32'hbfc00000 + 32'(4 * (k - 2)));
                chk("t1_inst_data", inst_data, 32'ha5000000 | 32'(k - 2));
            end
            advance();
        end

        // addr_ok withheld for five cycles, then accepted.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1);
            chk("t2_hold_valid", bus.ibus_valid, 32'd1);
            chk("t2_hold_addr", bus.ibus_address, 32'hbfc00000);
            advance();
        end
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("t2_acc_addr", bus.ibus_address, 32'hbfc00000);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t2_next_addr", bus.ibus_address, 32'hbfc00004);
        advance();

        // Decode stalled: buffer fills to four entries and issue stops.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b0);                 advance();
        drive(1'b1, 1'b1, 32'h11110000, 1'b0);          advance();
        drive(1'b1, 1'b1, 32'h11110001, 1'b0);          advance();
        drive(1'b1, 1'b1, 32'h11110002, 1'b0);          advance();
        drive(1'b1, 1'b1, 32'h11110003, 1'b0);
        chk("t3_full_valid", bus.ibus_valid, 32'd0);
        advance();
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t3_stall_valid", bus.ibus_valid, 32'd0);
        chk("t3_head_pc", inst_pc, 32'hbfc00000);
        chk("t3_head_data", inst_data, 32'h11110000);
        advance();
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("t3_pop_valid", bus.ibus_valid, 32'd0);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_reopen_valid", bus.ibus_valid, 32'd1);
        chk("t3_reopen_addr", bus.ibus_address, 32'hbfc00010);
        chk("t3_head1_pc", inst_pc, 32'hbfc00004);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_head2_data", inst_data, 32'h11110002);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_head3_pc", inst_pc, 32'hbfc0000c);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t3_drained", inst_valid, 32'd0);
        advance();

        // Redirect with two requests outstanding.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b0);                 advance();
        drive(1'b1, 1'b0, 32'd0, 1'b0);                 advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80001003;
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t4_full_valid", bus.ibus_valid, 32'd0);
        advance();
        drive(1'b1, 1'b1, 32'hdead0000, 1'b0);
        chk("t4_wait_valid", bus.ibus_valid, 32'd0);
        advance();
        drive(1'b1, 1'b1, 32'hdead0004, 1'b0);
        chk("t4_new_valid", bus.ibus_valid, 32'd1);
        chk("t4_new_addr", bus.ibus_address, 32'h80001000);
        chk("t4_new_uncache", bus.ibus_uncache, 32'd0);
        chk("t4_drop0", inst_valid, 32'd0);
        advance();
        drive(1'b0, 1'b1, 32'hcafe0000, 1'b0);
        chk("t4_drop1", inst_valid, 32'd0);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t4_inst_valid", inst_valid, 32'd1);
        chk("t4_inst_pc", inst_pc, 32'h80001000);
        chk("t4_inst_data", inst_data, 32'hcafe0000);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t4_single", inst_valid, 32'd0);
        advance();

        // Redirect while a request is held by addr_ok=0.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80001000;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t5_held_valid", bus.ibus_valid, 32'd1);
        chk("t5_held_addr", bus.ibus_address, 32'hbfc00000);
        advance();
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("t5_acc_addr", bus.ibus_address, 32'hbfc00000);
        advance();
        drive(1'b1, 1'b1, 32'hbad00000, 1'b1);
        chk("t5_new_addr", bus.ibus_address, 32'h80001000);
        chk("t5_new_uncache", bus.ibus_uncache, 32'd0);
        advance();
        drive(1'b0, 1'b1, 32'h600d0000, 1'b1);
        chk("t5_dropped", inst_valid, 32'd0);
        advance();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("t5_inst_valid", inst_valid, 32'd1);
        chk("t5_inst_pc", inst_pc, 32'h80001000);
        chk("t5_inst_data", inst_data, 32'h600d0000);
        advance();

        // Reset taken mid-transaction returns to the initial state.
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
